serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first subtractor computing `a - b` for two WIDTH-bit unsigned operands with a single registered borrow and one full-subtractor cell. It is the subtraction counterpart of the team's adder cells. It sits beside them in the datapath where area matters more than throughput. A start/busy/done handshake sequences each operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1 to 32.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a new operation; sampled on a rising edge when the block is not busy
- `a`  in  WIDTH  minuend; sampled on the accepting edge only
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only
- `busy`  out  1  high while bits are being processed
- `done`  out  1  one-cycle pulse: `diff` and `borrow` just updated
- `diff`  out  WIDTH  result `(a - b) mod 2^WIDTH`, held between operations
- `borrow`  out  1  final borrow out; 1 when `a < b`

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, internal registers 0.
- Start acceptance:
  - In IDLE or DONE, `start`=1 latches `a` and `b` into shift registers.
  - The same edge clears the borrow register and the bit counter, and enters RUN.
  - In RUN, `start` is ignored; no queueing.
- Per bit cell, with `x`=a_sr[0], `y`=b_sr[0], `bi`=borrow register:
  - Difference bit: `d = x^y^bi`.
  - Next borrow: `bo = (~x&y) | (~(x^y)&bi)`.
- RUN, each cycle:
  - Shift `d` into the result shift register from the MSB end.
  - Shift both operand registers right by one.
  - Store `bo` in the borrow register.
  - Increment the counter.
- RUN to DONE, on the edge that processes bit WIDTH-1:
  - Load `diff` with the completed result, including that edge's `d`.
  - Load `borrow` with that edge's `bo`.
- DONE:
  - `done`=1 for exactly one cycle.
  - With `start`=0, go to IDLE.
  - With `start`=1, start a new operation.
- `diff` and `borrow` change only on completion edges or reset. Intermediate shift values never appear on the outputs.
- Counter width is `$clog2(WIDTH+1)`. The counter never wraps within an operation.
- Reset asserted mid-operation:
  - The block returns immediately to IDLE with all outputs 0.
  - The aborted operation produces no `done`.

## Timing
- The accepting edge is E0.
- `busy` is high from E0 until edge E(WIDTH). It is registered and equals (state==RUN).
- The final bit is processed at E(WIDTH). At that edge `diff`/`borrow` update and `done` rises. `done` falls at E(WIDTH+1).
- Latency from start to `done` is WIDTH cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles, with `start` held in the DONE cycle.
- WIDTH=1 case: `busy` is high for one cycle and `done` follows immediately.
- `a` and `b` may change freely after E0.

## Configuration
- Macro `SERIAL_SUB_SAT_EN`.
- Defined:
  - At completion, if the final borrow is 1, `diff` loads 0 (saturate at zero).
  - `borrow` still reports 1.
- Undefined:
  - `diff` is the wrapped two's-complement result.
  - No saturation logic is synthesised.

## Test plan
- Basic subtraction: WIDTH=8, a=0x5A, b=0x23, start pulse → `done` 8 cycles after the accepting edge, `diff`=0x37, `borrow`=0, `busy` high exactly 8 cycles.
- Underflow: a=0x10, b=0x20 → `borrow`=1.
  - Without the macro: `diff`=0xF0.
  - With `SERIAL_SUB_SAT_EN`: `diff`=0x00.
- Borrow-chain extremes:
  - a=0x00, b=0x01 → `diff`=0xFF, `borrow`=1 (0x00 when saturating).
  - a=0xFF, b=0xFF → `diff`=0x00, `borrow`=0.
- Start ignored while busy: start a=0x80, b=0x01, then pulse `start` with a=0x11, b=0x11 during RUN → one `done` only, `diff`=0x7F. Outputs do not change until completion.
- Reset mid-run: assert `rst` at cycle 4 of a run → all outputs 0 immediately, no `done`. A new operation after release (a=0x09, b=0x03) gives 0x06.
- Back-to-back: hold `start` through the DONE cycle with a=0x03, b=0x01 → second `done` exactly 9 cycles after the first, `diff`=0x02. Also run exhaustively at WIDTH=1: 1−0=1 b0, 0−1=1 b1, 0−0=0 b0, 1−1=0 b0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with one full-subtractor cell and a start/busy/done handshake.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x, y, d_bit, bo;
  logic [WIDTH:0]   res_shift;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_sr_d  = res_sr_q;
    diff_d    = diff_q;
    bor_d     = bor_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;

    x         = a_sr_q[0];
    y         = b_sr_q[0];
    d_bit     = x ^ y ^ bor_q;
    bo        = (~x & y) | (~(x ^ y) & bor_q);
    // New bit enters at the MSB end; the widened vector keeps WIDTH=1 legal.
    res_shift = {d_bit, res_sr_q};
    res_next  = res_shift[WIDTH:1];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          bor_d    = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next;
        bor_d    = bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          borrow_d = bo;
`ifdef SERIAL_SUB_SAT_EN
          diff_d   = bo ? '0 : res_next;
`else
          diff_d   = res_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction, borrow is a < b.
  function automatic logic [31:0] ref_diff(input int unsigned a, input int unsigned b, input int w);
    logic [31:0] mask, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    r = (a - b) & mask;
`ifdef SERIAL_SUB_SAT_EN
    if (a < b) r = '0;
`endif
    return r;
  endfunction

  // Issue one 8-bit operation. If inj is set, pulse start with 0x11/0x11 during RUN.
  // Returns after sampling the done cycle (#1 after the completing edge).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit inj, input string tag);
    int cyc, busyc;
    bit held;
    logic [7:0] prev_diff;
    logic prev_bor;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    prev_diff = diff8; prev_bor = borrow8;
    cyc = 0; busyc = 0; held = 1;
    while (!done8 && cyc < 20) begin
      if (busy8) busyc++;
      if (diff8 !== prev_diff || borrow8 !== prev_bor) held = 0;
      if (inj && cyc == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h11; end
      if (inj && cyc == 4) start8 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 8);
    check({tag, " busy_cycles"}, busyc, 8);
    check({tag, " outputs_held"}, held, 1);
    check({tag, " diff"}, diff8, ref_diff(a, b, 8));
    check({tag, " borrow"}, borrow8, (a < b));
    check({tag, " busy_at_done"}, busy8, 0);
  endtask

  task automatic op1(input logic a, input logic b);
    int cyc;
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1 busy", busy1, 1);
    cyc = 0;
    while (!done1 && cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w1 latency", cyc, 1);
    check("w1 diff", diff1, ref_diff(a, b, 1));
    check("w1 borrow", borrow1, (a < b));
    @(posedge clk); #1;
    check("w1 done_pulse", done1, 0);
  endtask

  initial begin
    int cyc;
    bit saw_done;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst diff", diff8, 0);
    check("rst borrow", borrow8, 0);
    check("rst w1 diff", diff1, 0);
    @(negedge clk); rst = 1'b0;

    op8(8'h5A, 8'h23, 0, "basic");
    @(posedge clk); #1;
    check("basic done_pulse", done8, 0);
    op8(8'h10, 8'h20, 0, "underflow");
    op8(8'h00, 8'h01, 0, "chain_lo");
    op8(8'hFF, 8'hFF, 0, "chain_hi");

    // start pulse during RUN must be ignored, no queued op afterwards
    op8(8'h80, 8'h01, 1, "ignore");
    check("ignore diff_7f", diff8, 8'h7F);
    @(posedge clk); #1;
    check("ignore no_second_busy", busy8, 0);
    check("ignore no_second_done", done8, 0);
    repeat (10) @(posedge clk);
    #1;
    check("ignore still_idle", busy8, 0);

    // reset mid-run
    @(negedge clk); a8 = 8'h77; b8 = 8'h12; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("midrst busy", busy8, 0);
    check("midrst done", done8, 0);
    check("midrst diff", diff8, 0);
    check("midrst borrow", borrow8, 0);
    @(negedge clk); rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1;
    end
    check("midrst no_done", saw_done, 0);
    op8(8'h09, 8'h03, 0, "after_rst");

    // back-to-back with start held in DONE
    op8(8'h40, 8'h0F, 0, "b2b_first");
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h01;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b spacing", cyc, 9);
    check("b2b diff", diff8, 8'h02);
    check("b2b borrow", borrow8, 0);

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 0, "rand");
    end

    op1(1'b1, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b0, 1'b0);
    op1(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
